// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Definitions shared by the instruction-fetch slice:
//   - opcode constants the program counter decodes from op_code
//   - IO_BOUNDARY: byte address of the last instruction word
//   - MEM_AW: word-address width of the instruction memory
//   - fetch_state_e: fetch FSM states
//   - sat_inc2: saturating 2-bit increment for the re-issue counter
// -----------------------------------------------------------------------------
package mips_pkg;

    localparam logic [5:0]  OP_STALL1   = 6'd56;
    localparam logic [5:0]  OP_MOVE_SRC = 6'd57;
    localparam logic [5:0]  OP_MOVE_DST = 6'd59;
    localparam logic [31:0] IO_BOUNDARY = 32'(8191 * 4);
    localparam int          MEM_AW      = 13;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        FETCH  = 2'd1,
        REPEAT = 2'd2
    } fetch_state_e;

    function automatic logic [1:0] sat_inc2(input logic [1:0] v);
        return (v == 2'd3) ? v : v + 2'd1;
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_if
// Bundles the fetch-stage signals between the program counter / loader
// (master) and the fetch unit (slave).
//   pc          : byte address to fetch          (master -> slave)
//   ld_we       : program-load write enable       (master -> slave)
//   ld_addr     : program-load word address       (master -> slave)
//   ld_data     : program-load word               (master -> slave)
//   instr       : registered instruction word     (slave -> master)
//   op_code     : instr[31:26]                    (slave -> master)
//   move_data   : instr[15:0]                     (slave -> master)
//   instr_valid : instr holds a new fetch         (slave -> master)
//   refetch     : instr repeats previous address  (slave -> master)
//   repeat_cnt  : consecutive re-issues, sat. 3   (slave -> master)
//   addr_err    : fetch was misaligned/out of range (slave -> master)
// -----------------------------------------------------------------------------
interface instr_fetch_if;
    logic [31:0]                 pc;
    logic                        ld_we;
    logic [mips_pkg::MEM_AW-1:0] ld_addr;
    logic [31:0]                 ld_data;
    logic [31:0]                 instr;
    logic [5:0]                  op_code;
    logic [15:0]                 move_data;
    logic                        instr_valid;
    logic                        refetch;
    logic [1:0]                  repeat_cnt;
    logic                        addr_err;

    modport master (
        output pc, ld_we, ld_addr, ld_data,
        input  instr, op_code, move_data, instr_valid, refetch, repeat_cnt, addr_err
    );

    modport slave (
        input  pc, ld_we, ld_addr, ld_data,
        output instr, op_code, move_data, instr_valid, refetch, repeat_cnt, addr_err
    );
endinterface

// File: rtl/instr_mem.sv
// -----------------------------------------------------------------------------
// instr_mem
// Synchronous single-read, single-write instruction RAM. No reset: contents
// survive a processor reset.
//   clk     : clock
//   i_raddr : read word address (data appears after the next edge)
//   o_rdata : registered read data
//   i_we    : write enable
//   i_waddr : write word address
//   i_wdata : write data
// -----------------------------------------------------------------------------
module instr_mem #(
    parameter int DEPTH = 8192,
    parameter int AW    = 13
) (
    input  logic          clk,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    // Read and write in the same non-blocking step: a read of the address
    // being written returns the old word.
    always_ff @(posedge clk) begin
        r_rdata <= r_mem[i_raddr];
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Instruction fetch stage: one-cycle synchronous fetch from instr_mem, fault
// substitution, and a FILL/FETCH/REPEAT FSM that flags re-issues of the same
// address for multi-cycle ops.
//   clk   : clock, all state changes on the rising edge
//   rst_n : synchronous active-low reset (memory contents are kept)
//   bus   : instr_fetch_if.slave (pc, program-load port, fetch results)
// -----------------------------------------------------------------------------
module instr_fetch
    import mips_pkg::*;
#(
    parameter int          MEM_WORDS = 8192,
    parameter logic [31:0] NOP_WORD  = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_if.slave  bus
);

    localparam logic [31:0] LP_BYTE_LIMIT = 32'(MEM_WORDS) << 2;

    fetch_state_e r_state;
    fetch_state_e w_state_nxt;
    logic [31:0]  r_last_pc;
    logic         r_refetch;
    logic [1:0]   r_repeat_cnt;
    logic         r_addr_err;
    logic         r_valid;
    logic         r_ld_d;
    logic         w_refetch_nxt;
    logic [1:0]   w_repeat_nxt;
    logic         w_fault;
    logic         w_same_pc;
    logic [31:0]  w_rdata;
    logic [31:0]  w_instr;

    instr_mem #(
        .DEPTH (MEM_WORDS),
        .AW    (MEM_AW)
    ) u_mem (
        .clk     (clk),
        .i_raddr (bus.pc[14:2]),
        .o_rdata (w_rdata),
        .i_we    (bus.ld_we),
        .i_waddr (bus.ld_addr),
        .i_wdata (bus.ld_data)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_refetch_nxt = 1'b0;
        w_repeat_nxt  = 2'd0;
        w_fault       = (bus.pc[1:0] != 2'b00) || (bus.pc >= LP_BYTE_LIMIT);
        // Compared against the full last pc, faulting addresses included.
        w_same_pc     = (bus.pc == r_last_pc);

        case (r_state)
            FILL: begin
                w_state_nxt = FETCH;
            end
            FETCH: begin
                if (w_same_pc) begin
                    w_state_nxt   = REPEAT;
                    w_refetch_nxt = 1'b1;
                    w_repeat_nxt  = 2'd1;
                end
            end
            REPEAT: begin
                if (w_same_pc) begin
                    w_refetch_nxt = 1'b1;
                    w_repeat_nxt  = sat_inc2(r_repeat_cnt);
                end else begin
                    w_state_nxt = FETCH;
                end
            end
            default: begin
                w_state_nxt = FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= FILL;
            r_last_pc    <= '0;
            r_refetch    <= 1'b0;
            r_repeat_cnt <= 2'd0;
            r_addr_err   <= 1'b0;
            r_valid      <= 1'b0;
            r_ld_d       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_pc    <= bus.pc;
            r_refetch    <= w_refetch_nxt;
            r_repeat_cnt <= w_repeat_nxt;
            r_addr_err   <= w_fault;
            // A write suppresses valid on the fetch after the one it shares
            // a cycle with, hence the one-cycle delayed load flag.
            r_valid      <= !r_ld_d;
            r_ld_d       <= bus.ld_we;
        end
    end

    // The RAM output register is the instr register; FILL (reset) and
    // fault flags, both registered, substitute the NOP word.
    assign w_instr         = ((r_state == FILL) || r_addr_err) ? NOP_WORD : w_rdata;
    assign bus.instr       = w_instr;
    assign bus.op_code     = w_instr[31:26];
    assign bus.move_data   = w_instr[15:0];
    assign bus.instr_valid = r_valid;
    assign bus.refetch     = r_refetch;
    assign bus.repeat_cnt  = r_repeat_cnt;
    assign bus.addr_err    = r_addr_err;

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter MEM_WORDS, default 8192, instruction memory depth in 32-bit words (byte space 0..32767).
REQ-002 Parameter NOP_WORD, default 32'h0000_0000, word substituted on any fetch fault.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 pc  input  32  byte address of the instruction to fetch, driven by the program counter's pcout.
REQ-006 ld_we  input  1  program-load write enable.
REQ-007 ld_addr  input  13  program-load word address.
REQ-008 ld_data  input  32  program-load word.
REQ-009 instr  output  32  registered instruction word.
REQ-010 op_code  output  6  instr[31:26]; fed back to the program counter.
REQ-011 move_data  output  16  instr[15:0]; fed back to the program counter.
REQ-012 instr_valid  output  1  instr holds a newly fetched instruction.
REQ-013 refetch  output  1  the current instr repeats the previous address (multi-cycle op re-issue).
REQ-014 repeat_cnt  output  2  consecutive re-issues of the same address, saturating at 3.
REQ-015 addr_err  output  1  the current fetch was misaligned or out of range.

Function
REQ-016 Memory reads shall be synchronous with 1-cycle latency: pc sampled at edge N yields instr after edge N.
REQ-017 Word index shall be pc[14:2]; pc[1:0]!=0 or pc>=MEM_WORDS*4 shall set addr_err=1 and instr=NOP_WORD for that fetch.
REQ-018 op_code and move_data shall be pure slices of the registered instr, with no extra latency.
REQ-019 FSM states: FILL, FETCH, REPEAT; reset enters FILL.
REQ-020 FILL: instr_valid=0; on the next edge, capture the fetch and go to FETCH.
REQ-021 FETCH: when pc equals the last captured pc, go to REPEAT with refetch=1 and repeat_cnt=1; otherwise stay in FETCH with refetch=0 and repeat_cnt=0.
REQ-022 REPEAT: when the same pc is held, increment repeat_cnt and saturate at 3; when pc changes, return to FETCH with repeat_cnt=0.
REQ-023 instr_valid shall be 1 in FETCH and REPEAT, except in the cycle after an ld_we write.
REQ-024 When ld_we=1, write mem[ld_addr]=ld_data; a fetch in the same cycle shall complete, but the following instr_valid shall be 0.
REQ-025 A same-cycle read and write to the same address shall return the old data (read-before-write).
REQ-026 In the cycle after a faulting fetch, refetch compare shall use the faulting pc.

Reset
REQ-027 On a rst_n=0 edge: instr=NOP_WORD, instr_valid=0, refetch=0, repeat_cnt=0, addr_err=0, last-pc register=0, state=FILL.
REQ-028 Reset shall not clear memory contents; a mid-program reset restarts at FILL with the program intact.
REQ-029 ld_we shall be honoured while rst_n=0 so that a program can be loaded under reset.

Structure
REQ-030 A shared package mips_pkg shall hold: opcode constants OP_STALL1=56, OP_MOVE_SRC=57, OP_MOVE_DST=59; IO_BOUNDARY=8191*4; the fetch FSM state enum.
REQ-031 One sub-module, instr_mem, shall contain the synchronous single-read, single-write RAM; instr_fetch shall hold the FSM, last-pc register and fault logic.

Verification
REQ-032 Load mem[0..2]={32'h2001_0005, 32'hE000_0000, 32'h2002_0007}, release reset, and drive pc=0,4,8 -> instr matches each word one cycle later; instr_valid=0 only in the FILL cycle.
REQ-033 Drive pc=4 for two cycles with word op 56 -> op_code=56; second cycle refetch=1, repeat_cnt=1; next pc=8 gives refetch=0.
REQ-034 Hold pc=12 for 5 cycles with an op 57 word -> repeat_cnt=1,2,3,3; move_data equals the loaded low 16 bits.
REQ-035 Drive pc=6, then pc=32768 -> addr_err=1 and instr=0 each time; pc=0 next clears addr_err.
REQ-036 Drive ld_we to addr 3 while fetching pc=12 -> old word returned with instr_valid=1, next cycle instr_valid=0; a refetch of pc=12 returns the new word.
REQ-037 Assert rst_n=0 during a REPEAT sequence -> all outputs take reset values next edge; after release, pc=0 fetches the unchanged mem[0].
